// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer that turns a strobed 8-bit offset-binary ADC stream into
// FRAME_LEN-sample AXI-Stream frames for an FFT core.
//
// Ports:
//   clk          clock, all logic on rising edge
//   rstn         asynchronous active-low reset
//   i_enable     capture enable (level); low discards any partial frame
//   i_sample_en  one-cycle strobe marking a valid sample on i_wave_data
//   i_wave_data  8-bit unsigned offset-binary sample
//   o_tvalid     stream data valid
//   i_tready     downstream ready
//   o_tdata      {imag, real}, each OUT_W bits, imag always 0
//   o_tlast      marks sample FRAME_LEN-1 of a frame
//   o_overflow   sticky, set when a sample is dropped because no bank is free
//   o_frame_cnt  number of frames fully transferred (wraps)
module fft_frame_feeder #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned OUT_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_enable,
    input  logic               i_sample_en,
    input  logic [7:0]         i_wave_data,
    output logic               o_tvalid,
    input  logic               i_tready,
    output logic [2*OUT_W-1:0] o_tdata,
    output logic               o_tlast,
    output logic               o_overflow,
    output logic [15:0]        o_frame_cnt
);

    localparam int unsigned AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LastIdx = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

    logic [7:0]    mem [2][FRAME_LEN];
    logic [7:0]    rd_q;

    logic          fill_bank_q;
    logic [AW-1:0] wp_q;
    logic [1:0]    full_q, full_d;
    logic          overflow_q;

    state_e        state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          handshake, last_beat, free_now, fill_free, sample, wr_en, wr_last;

    assign handshake = (state_q == StStream) && i_tready;
    assign last_beat = (rd_idx_q == LastIdx);
    assign free_now  = handshake && last_beat;
    // A bank released this very cycle may already take the incoming write.
    assign fill_free = !full_q[fill_bank_q] || (free_now && (rd_bank_q == fill_bank_q));
    assign sample    = i_enable && i_sample_en;
    assign wr_en     = sample && fill_free;
    assign wr_last   = wr_en && (wp_q == LastIdx);

    // Release before set, so a same-cycle free and refill leaves the bank full.
    always_comb begin
        full_d = full_q;
        if (free_now) full_d[rd_bank_q] = 1'b0;
        if (wr_last)  full_d[fill_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_bank_q <= 1'b0;
            wp_q        <= '0;
            full_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (!i_enable) begin
                wp_q <= '0;
            end else if (wr_en) begin
                if (wr_last) begin
                    wp_q        <= '0;
                    fill_bank_q <= ~fill_bank_q;
                end else begin
                    wp_q <= wp_q + 1'b1;
                end
            end else if (sample) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        unique case (state_q)
            StIdle: begin
                if (full_q != 2'b00) begin
                    state_d = StFetch;
                    // With both full, the bank the writer points at is the older one.
                    rd_bank_d = (full_q == 2'b11) ? fill_bank_q : full_q[1];
                end
            end
            StFetch: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                rd_idx_d = '0;
                state_d  = StStream;
            end
            StStream: begin
                if (i_tready) begin
                    // Read the next sample on the accepting edge so there is no bubble.
                    rd_en    = 1'b1;
                    rd_addr  = rd_idx_q + 1'b1;
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (last_beat) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (full_q[~rd_bank_q]) begin
                            state_d   = StFetch;
                            rd_bank_d = ~rd_bank_q;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Sample storage, no reset needed: stale contents are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) mem[fill_bank_q][wp_q] <= i_wave_data;
        if (rd_en) rd_q <= mem[rd_bank_q][rd_addr];
    end

    // Offset binary to two's complement: invert the MSB, then sign-extend.
    logic signed [7:0]       re8;
    logic signed [OUT_W-1:0] re_ext;
    assign re8    = {~rd_q[7], rd_q[6:0]};
    assign re_ext = OUT_W'(re8);

    assign o_tvalid    = (state_q == StStream);
    assign o_tlast     = o_tvalid && last_beat;
    assign o_tdata     = o_tvalid ? {{OUT_W{1'b0}}, re_ext} : '0;
    assign o_overflow  = overflow_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
